// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl
// ---------------------------------------------------------------------------
// Loadable instruction memory for the ARM-style core. A post-reset clear
// sequence fills every word with FILL_WORD (a NOP), after which the block
// serves a registered fetch port and accepts writes from a loader port.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   reset        synchronous active-low reset
//   fetch_req    fetch request, sampled each cycle unless the output is held
//   fetch_addr   byte address of the instruction to fetch
//   fetch_stall  consumer stall, holds the current fetch output while valid
//   fetch_valid  fetch_data / fetch_fault are valid this cycle
//   fetch_data   fetched instruction (FILL_WORD on a faulting fetch)
//   fetch_fault  fetch was misaligned or beyond the end of the array
//   load_we      loader write strobe
//   load_addr    loader byte address
//   load_data    loader write data
//   load_ready   loader writes are accepted this cycle
//   init_done    clear sequence has finished
// ---------------------------------------------------------------------------
module instr_mem_ctrl #(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          DEPTH     = 64,
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [DATA_W-1:0]    FILL_WORD = 32'hE1A00000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              init_done
);

  // Byte-offset width and word-index width.
  localparam int unsigned OFF   = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Address decode for both ports.
  logic             f_mis, f_oor, f_bad;
  logic             l_mis, l_oor, l_ok;
  logic [IDX_W-1:0] f_idx, l_idx;
  logic             load_fire, bypass;

  assign f_idx = fetch_addr[OFF+IDX_W-1:OFF];
  assign l_idx = load_addr[OFF+IDX_W-1:OFF];

  // Byte-wide words have no offset bits and can never be misaligned.
  generate
    if (OFF == 0) begin : g_no_off
      assign f_mis = 1'b0;
      assign l_mis = 1'b0;
    end else begin : g_off
      assign f_mis = |fetch_addr[OFF-1:0];
      assign l_mis = |load_addr[OFF-1:0];
    end
  endgenerate

  // Index >= DEPTH is equivalent to any address bit above the index being set,
  // since DEPTH is a power of two.
  generate
    if (OFF + IDX_W < ADDR_W) begin : g_hi
      assign f_oor = |fetch_addr[ADDR_W-1:OFF+IDX_W];
      assign l_oor = |load_addr[ADDR_W-1:OFF+IDX_W];
    end else begin : g_no_hi
      assign f_oor = 1'b0;
      assign l_oor = 1'b0;
    end
  endgenerate

  assign f_bad     = f_mis | f_oor;
  assign l_ok      = !(l_mis | l_oor);
  assign load_fire = load_we && load_ready && l_ok;

  // A load and a fetch hitting the same word in the same cycle return the
  // incoming load data rather than the stale array contents.
  assign bypass = load_fire && !f_bad && (l_idx == f_idx);

  // State register and clear pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state logic and selection of the single array write port.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mem_we    = 1'b0;
    mem_waddr = l_idx;
    mem_wdata = load_data;
    case (state)
      CLEAR: begin
        mem_we    = reset;
        mem_waddr = ptr;
        mem_wdata = FILL_WORD;
        ptr_nxt   = ptr + IDX_W'(1);
        if (ptr == LAST_IDX) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        mem_we = reset && load_fire;
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Instruction array; initialised only by the clear sequence.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // init_done and load_ready rise on the same edge that enters RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      init_done  <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      init_done  <= (state_nxt == RUN);
      load_ready <= (state_nxt == RUN);
    end
  end

  // Fetch output register. A stalled valid output is frozen and new requests
  // are dropped, not queued; with fetch_req low the data and fault flag keep
  // their last values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_data  <= FILL_WORD;
    end else if (state != RUN) begin
      fetch_valid <= 1'b0;
    end else if (!(fetch_valid && fetch_stall)) begin
      fetch_valid <= fetch_req;
      if (fetch_req) begin
        if (f_bad) begin
          fetch_data  <= FILL_WORD;
          fetch_fault <= 1'b1;
        end else begin
          fetch_data  <= bypass ? load_data : mem[f_idx];
          fetch_fault <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl
// ---------------------------------------------------------------------------
// Directed self-checking bench for instr_mem_ctrl with the default
// parameters (32-bit words, 64 entries, NOP fill 0xE1A00000).
// ---------------------------------------------------------------------------
module tb_instr_mem_ctrl;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_stall;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_fault;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        init_done;

  int errors = 0;
  int checks = 0;

  instr_mem_ctrl #(
    .DATA_W   (32),
    .DEPTH    (64),
    .ADDR_W   (32),
    .FILL_WORD(32'hE1A00000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .fetch_fault(fetch_fault),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready),
    .init_done  (init_done)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 ns so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] faddr,
                               input logic stall, input logic we,
                               input logic [31:0] laddr, input logic [31:0] ldata);
    fetch_req   = req;
    fetch_addr  = faddr;
    fetch_stall = stall;
    load_we     = we;
    load_addr   = laddr;
    load_data   = ldata;
  endtask

  task automatic checkBit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ev,
                             input logic [31:0] ed, input logic ef);
    checks++;
    assert (fetch_valid === ev) else begin
      errors++;
      $error("[TB] FAIL %s.valid got=%0b exp=%0b", tag, fetch_valid, ev);
    end
    checks++;
    assert (fetch_data === ed) else begin
      errors++;
      $error("[TB] FAIL %s.data got=%08h exp=%08h", tag, fetch_data, ed);
    end
    checks++;
    assert (fetch_fault === ef) else begin
      errors++;
      $error("[TB] FAIL %s.fault got=%0b exp=%0b", tag, fetch_fault, ef);
    end
  endtask

  // Release reset and walk the 64-cycle clear with fetch_req held high.
  task automatic runClear(input string tag);
    reset = 1'b1;
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) begin
        checkBit({tag, ".done63"}, init_done, 1'b0);
        checkBit({tag, ".ready63"}, load_ready, 1'b0);
      end
      if (i == 64) begin
        checkBit({tag, ".done64"}, init_done, 1'b1);
        checkBit({tag, ".ready64"}, load_ready, 1'b1);
      end
      checkBit({tag, ".clrvalid"}, fetch_valid, 1'b0);
    end
  endtask

  initial begin
    $display("[TB] instr_mem_ctrl directed test");
    reset = 1'b0;
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("reset", 1'b0, NOP, 1'b0);
    checkBit("reset.done", init_done, 1'b0);
    checkBit("reset.ready", load_ready, 1'b0);

    // Clear sequence, then the first fetch of a cleared word.
    runClear("clr1");
    tick();
    checkOutput("fetch0_nop", 1'b1, NOP, 1'b0);

    // Program two words, then fetch them back to back.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 32'hE3A0204B);
    tick();
    checkOutput("load0", 1'b0, NOP, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h04, 32'hE04F000F);
    tick();
    applyStimulus(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("fetch00", 1'b1, 32'hE3A0204B, 1'b0);
    applyStimulus(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("fetch04", 1'b1, 32'hE04F000F, 1'b0);

    // Faulting fetches.
    applyStimulus(1'b1, 32'h02, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("misalign", 1'b1, NOP, 1'b1);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("oor", 1'b1, NOP, 1'b1);

    // Out-of-range write must not alias onto word 0 or word 63.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
    tick();
    checkOutput("oor_wr_idle", 1'b0, NOP, 1'b1);
    applyStimulus(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("word0_kept", 1'b1, 32'hE3A0204B, 1'b0);
    applyStimulus(1'b1, 32'hFC, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("word63_kept", 1'b1, NOP, 1'b0);

    // Stall hold for three cycles with fetch_req toggling.
    applyStimulus(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("pre_stall", 1'b1, 32'hE04F000F, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i[0] ? 1'b1 : 1'b0, 32'h00, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      checkOutput("stall_hold", 1'b1, 32'hE04F000F, 1'b0);
    end
    applyStimulus(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("post_stall", 1'b1, 32'hE3A0204B, 1'b0);

    // Idle cycle keeps data, then a stall with no valid output is ignored.
    applyStimulus(1'b0, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("idle_keep", 1'b0, 32'hE3A0204B, 1'b0);
    applyStimulus(1'b1, 32'h04, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("stall_novalid", 1'b1, 32'hE04F000F, 1'b0);

    // Same-cycle load and fetch of word 2.
    applyStimulus(1'b1, 32'h08, 1'b0, 1'b1, 32'h08, 32'hE3A04055);
    tick();
    checkOutput("bypass", 1'b1, 32'hE3A04055, 1'b0);
    applyStimulus(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("bypass_stored", 1'b1, 32'hE3A04055, 1'b0);

    // Reset in RUN drops the fetch; reset again at clear pointer 20.
    applyStimulus(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    tick();
    checkOutput("rst_run", 1'b0, NOP, 1'b0);
    checkBit("rst_run.done", init_done, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b0;
    tick();
    checkBit("rst_clr20.done", init_done, 1'b0);
    runClear("clr2");

    // Load a word, then reset from RUN and confirm everything reads as NOP.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'h12345678);
    tick();
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("fetch10", 1'b1, 32'h12345678, 1'b0);
    reset = 1'b0;
    tick();
    runClear("clr3");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("cleared10", 1'b1, NOP, 1'b0);
    applyStimulus(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("cleared00", 1'b1, NOP, 1'b0);
    applyStimulus(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("cleared08", 1'b1, NOP, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised, loadable instruction memory for the ARM-style processor core; replaces the fixed, combinational, hard-coded 64-word ROM.
- Synchronous fetch port with a valid/stall handshake and alignment/range fault detection.
- Loader write port lets a boot path or testbench program the array at run time.
- Post-reset clear FSM fills every word with a NOP so that unloaded locations execute harmlessly.

Parameters:
- DATA_W, 32, instruction width in bits; multiple of 8, power of two.
- DEPTH, 64, number of instruction words; power of two, at least 2.
- ADDR_W, 32, byte-address width of the fetch and load ports.
- FILL_WORD, 32'hE1A00000, clear value and fault return value (MOV r0,r0).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- fetch_req  in  1  fetch request; sampled every cycle unless the output is held.
- fetch_addr  in  ADDR_W  byte address of the instruction.
- fetch_stall  in  1  consumer stall; holds the current fetch output.
- fetch_valid  out  1  fetch_data/fetch_fault are valid this cycle.
- fetch_data  out  DATA_W  fetched instruction.
- fetch_fault  out  1  fetch was misaligned or out of range.
- load_we  in  1  loader write strobe.
- load_addr  in  ADDR_W  loader byte address.
- load_data  in  DATA_W  loader write data.
- load_ready  out  1  loader writes are accepted this cycle.
- init_done  out  1  clear sequence has finished.

Behaviour:
- Address decode:
  - OFF = log2(DATA_W/8) low bits form the byte offset.
  - Word index = addr[ADDR_W-1:OFF].
  - Misaligned: offset != 0. Out of range: index >= DEPTH.
- Reset (reset==0 at a clock edge):
  - Outputs: fetch_valid=0, fetch_fault=0, fetch_data=FILL_WORD, load_ready=0, init_done=0.
  - FSM enters CLEAR with the clear pointer at 0.
  - Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from index 0; any in-flight fetch is dropped.
- FSM:
  - CLEAR:
    - Writes FILL_WORD to word[ptr] each cycle and increments ptr.
    - After writing DEPTH-1, moves to RUN on the next edge, so CLEAR lasts exactly DEPTH cycles after reset release.
    - fetch_req and load_we are ignored; fetch_valid stays 0.
  - RUN:
    - init_done=1 and load_ready=1, both registered.
    - Stays in RUN until reset.
- Fetch, RUN only, latency 1:
  - Hold: if fetch_valid && fetch_stall, fetch_data, fetch_fault and fetch_valid keep their values, and fetch_req is ignored (not queued).
  - Otherwise, on each edge: fetch_valid <= fetch_req.
  - In-range, aligned request: fetch_data <= word[index], fetch_fault <= 0.
  - Faulting request: fetch_data <= FILL_WORD, fetch_fault <= 1.
  - When fetch_req==0, fetch_data and fetch_fault keep their previous values.
  - fetch_stall with fetch_valid==0 has no effect.
- Load, RUN only:
  - When load_we && load_ready, word[index] <= load_data.
  - Misaligned or out-of-range writes are silently discarded; no other word is modified.
- Same-cycle load and fetch to the same word: the fetch returns the new load_data (write-first bypass).
- Read-only operation is permitted: load_we tied 0 leaves the FILL_WORD contents; the array is initialised only by CLEAR (no file preload).

Test Plan:
- Reset, then 64 idle cycles (DEPTH=64) -> init_done rises exactly on cycle 64 after reset release; fetch_req held high during CLEAR gives fetch_valid=0 throughout; a fetch at 0x00 then returns 0xE1A00000, fault=0.
- Load 0x00=0xE3A0204B and 0x04=0xE04F000F, then back-to-back fetches 0x00, 0x04 -> valid on the following cycles with data 0xE3A0204B then 0xE04F000F.
- Fetch 0x02 (misaligned) and 0x100 (index 64, out of range) -> valid=1, fault=1, data=0xE1A00000; a write to 0x100 leaves words 0 and 63 unchanged.
- fetch_stall high for 3 cycles while valid with data 0xE04F000F and fetch_req toggling -> output is held; the first new fetch completes 1 cycle after stall drops.
- Load 0x08=0xE3A04055 with a fetch of 0x08 in the same cycle -> next cycle data=0xE3A04055 (bypass).
- reset pulsed low at CLEAR ptr=20 and again in RUN after loading -> full 64-cycle CLEAR repeats; loaded words read back as 0xE1A00000.
